apb_cw305_mailbox: RTL and testbench



---
 rtl/apb_cw305_mailbox.sv | 167 ++++++++++++++++
 tb/tb_apb_cw305_mailbox.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cw305_mailbox.sv
// APB slave for the CW305 host mailbox: RX FIFO for host words, TX data/flags
// toward the host with a pending/ack handshake, and an RX interrupt.
module apb_cw305_mailbox #(
    parameter int unsigned pRX_DEPTH       = 4,
    parameter int unsigned pAPB_ADDR_WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [pAPB_ADDR_WIDTH-1:0] PADDR,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [31:0]                PWDATA,
    output logic [31:0]                PRDATA,
    output logic                       PREADY,
    output logic                       PSLVERR,
    input  logic [31:0]                usb_data_i,
    input  logic                       usb_rd_strobe_i,
    input  logic [31:0]                ext_flags_i,
    output logic [31:0]                pulp_data_o,
    output logic [31:0]                pulp_flags_o,
    output logic                       rx_irq_o
);

    localparam int unsigned PtrW = (pRX_DEPTH > 1) ? $clog2(pRX_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(pRX_DEPTH) + 1;

    localparam logic [2:0] AddrRxData  = 3'd0;
    localparam logic [2:0] AddrTxData  = 3'd1;
    localparam logic [2:0] AddrStatus  = 3'd2;
    localparam logic [2:0] AddrExt     = 3'd3;
    localparam logic [2:0] AddrPFlags  = 3'd4;
    localparam logic [2:0] AddrCtrl    = 3'd5;

    logic [31:0]     r_mem [pRX_DEPTH];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;
    logic            r_overrun;
    logic [31:0]     r_tx_data;
    logic            r_tx_pending;
    logic [30:0]     r_pulp_flags;
    logic            r_irq_en;
    logic            r_rx_irq;
    logic            r_strobe_q;
    logic [31:0]     r_ext_meta;
    logic [31:0]     r_ext_sync;
    logic            r_ack_q;

    logic [2:0]  w_idx;
    logic        w_access;
    logic        w_empty;
    logic        w_full;
    logic        w_ro;
    logic        w_err;
    logic        w_wr;
    logic        w_pop;
    logic        w_push_edge;
    logic        w_push;
    logic        w_ack;
    logic [4:0]  w_count5;
    logic [31:0] w_rdata;
    logic        w_unused_addr;

    assign w_idx         = PADDR[4:2];
    assign w_unused_addr = ^{PADDR[pAPB_ADDR_WIDTH-1:5], PADDR[1:0]};
    assign w_access      = PSEL & PENABLE;
    assign w_empty       = (r_count == '0);
    assign w_full        = (r_count == CntW'(pRX_DEPTH));
    assign w_count5      = 5'(r_count);
    assign w_ro          = (w_idx == AddrRxData) | (w_idx == AddrStatus) | (w_idx == AddrExt);

    // Erroring accesses are squashed here so they cannot commit or pop.
    assign w_err = w_access & ((w_idx > AddrCtrl) | (PWRITE & w_ro) |
                               (~PWRITE & (w_idx == AddrRxData) & w_empty));
    assign w_wr  = w_access & PWRITE & ~w_err;
    assign w_pop = w_access & ~PWRITE & ~w_err & (w_idx == AddrRxData);

    assign w_push_edge = usb_rd_strobe_i & ~r_strobe_q;
    assign w_push      = w_push_edge & (~w_full | w_pop);
    assign w_ack       = r_ext_sync[0] & ~r_ack_q;

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            AddrRxData: w_rdata = r_mem[r_rd_ptr];
            AddrTxData: w_rdata = r_tx_data;
            AddrStatus: w_rdata = {24'd0, w_count5, r_overrun, r_tx_pending, ~w_empty};
            AddrExt:    w_rdata = r_ext_sync;
            AddrPFlags: w_rdata = {r_pulp_flags, r_tx_pending};
            AddrCtrl:   w_rdata = {31'd0, r_irq_en};
            default:    w_rdata = '0;
        endcase
    end

    assign PRDATA       = (w_access & ~PWRITE & ~w_err) ? w_rdata : '0;
    assign PSLVERR      = w_err;
    assign PREADY       = 1'b1;
    assign pulp_data_o  = r_tx_data;
    assign pulp_flags_o = {r_pulp_flags, r_tx_pending};
    assign rx_irq_o     = r_rx_irq;

    // Storage only; every read of it is qualified by a non-empty FIFO.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= usb_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overrun    <= 1'b0;
            r_tx_data    <= '0;
            r_tx_pending <= 1'b0;
            r_pulp_flags <= '0;
            r_irq_en     <= 1'b0;
            r_rx_irq     <= 1'b0;
            // Held high so a strobe already high at release is not a push.
            r_strobe_q   <= 1'b1;
            r_ext_meta   <= '0;
            r_ext_sync   <= '0;
            r_ack_q      <= 1'b0;
        end else begin
            r_strobe_q <= usb_rd_strobe_i;
            r_ext_meta <= ext_flags_i;
            r_ext_sync <= r_ext_meta;
            r_ack_q    <= r_ext_sync[0];
            r_rx_irq   <= r_irq_en & ~w_empty;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            if (w_push & ~w_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (w_pop & ~w_push) begin
                r_count <= r_count - CntW'(1);
            end

            if (w_push_edge & w_full & ~w_pop) begin
                r_overrun <= 1'b1;
            end else if (w_wr & (w_idx == AddrCtrl) & PWDATA[1]) begin
                r_overrun <= 1'b0;
            end

            if (w_wr & (w_idx == AddrTxData)) begin
                r_tx_data    <= PWDATA;
                r_tx_pending <= 1'b1;
            end else if (w_ack) begin
                r_tx_pending <= 1'b0;
            end

            if (w_wr & (w_idx == AddrPFlags)) begin
                r_pulp_flags <= PWDATA[31:1];
            end
            if (w_wr & (w_idx == AddrCtrl)) begin
                r_irq_en <= PWDATA[0];
            end
        end
    end

endmodule

// File: tb/tb_apb_cw305_mailbox.sv
// Bench for apb_cw305_mailbox: directed scenarios plus random traffic, all
// checked against a queue-based behavioural model of the mailbox.
module tb_apb_cw305_mailbox;

    localparam int unsigned Depth = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [31:0] usb_data;
    logic        strobe;
    logic [31:0] ext;
    logic [31:0] pulp_data_o, pulp_flags_o;
    logic        rx_irq_o;

    apb_cw305_mailbox #(
        .pRX_DEPTH      (Depth),
        .pAPB_ADDR_WIDTH(12)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .PADDR          (paddr),
        .PSEL           (psel),
        .PENABLE        (penable),
        .PWRITE         (pwrite),
        .PWDATA         (pwdata),
        .PRDATA         (PRDATA),
        .PREADY         (PREADY),
        .PSLVERR        (PSLVERR),
        .usb_data_i     (usb_data),
        .usb_rd_strobe_i(strobe),
        .ext_flags_i    (ext),
        .pulp_data_o    (pulp_data_o),
        .pulp_flags_o   (pulp_flags_o),
        .rx_irq_o       (rx_irq_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    logic [31:0] q_rx[$];
    bit          m_overrun, m_pending, m_irq_en, m_irq_o, m_strb_prev;
    logic [31:0] m_tx;
    logic [30:0] m_pflags;
    logic [31:0] h0, h1, h2;   // ext_flags_i as sampled 1, 2, 3 edges ago
    logic        last_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q_rx.delete();
        m_overrun   = 0;
        m_pending   = 0;
        m_irq_en    = 0;
        m_irq_o     = 0;
        m_strb_prev = 1;
        m_tx        = '0;
        m_pflags    = '0;
        h0 = '0; h1 = '0; h2 = '0;
    endtask

    function automatic bit m_err(input logic [2:0] idx, input bit w);
        return (idx >= 3'd6) || (w && (idx == 3'd0 || idx == 3'd2 || idx == 3'd3)) ||
               (!w && idx == 3'd0 && q_rx.size() == 0);
    endfunction

    function automatic logic [31:0] m_rdata(input logic [2:0] idx);
        logic [4:0] cnt;
        cnt = 5'(q_rx.size());
        case (idx)
            3'd0: return (q_rx.size() != 0) ? q_rx[0] : 32'h0;
            3'd1: return m_tx;
            3'd2: return {24'd0, cnt, m_overrun, m_pending, q_rx.size() != 0};
            3'd3: return h1;
            3'd4: return {m_pflags, m_pending};
            3'd5: return 32'(m_irq_en);
            default: return 32'h0;
        endcase
    endfunction

    // One clock edge: advance the model from the inputs held across it, then
    // compare the registered outputs on the following falling edge.
    task automatic tick();
        bit acc, err, pop, push, ack, wr;
        logic [2:0] idx;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            acc  = psel && penable;
            idx  = paddr[4:2];
            err  = acc && m_err(idx, pwrite);
            wr   = acc && pwrite && !err;
            pop  = acc && !pwrite && !err && idx == 3'd0;
            push = strobe && !m_strb_prev;
            ack  = h1[0] && !h2[0];
            m_irq_o = m_irq_en && q_rx.size() != 0;
            if (wr && idx == 3'd5) begin
                m_irq_en = pwdata[0];
                if (pwdata[1]) m_overrun = 0;
            end
            if (wr && idx == 3'd4) m_pflags = pwdata[31:1];
            if (wr && idx == 3'd1) begin
                m_tx      = pwdata;
                m_pending = 1;
            end else if (ack) begin
                m_pending = 0;
            end
            if (pop) void'(q_rx.pop_front());
            if (push) begin
                if (q_rx.size() < Depth) q_rx.push_back(usb_data);
                else m_overrun = 1;
            end
            h2 = h1; h1 = h0; h0 = ext;
            m_strb_prev = strobe;
        end
        @(negedge clk);
        check_val("pulp_data_o", pulp_data_o, m_tx);
        check_val("pulp_flags_o", pulp_flags_o, {m_pflags, m_pending});
        check_val("rx_irq_o", 32'(rx_irq_o), 32'(m_irq_o));
        check_val("pready", 32'(PREADY), 32'h1);
    endtask

    task automatic apb(input bit w, input logic [11:0] a, input logic [31:0] wd,
                       input bit sa, input logic [31:0] sd, output logic [31:0] rd);
        bit          exp_err;
        logic [31:0] exp_rd;
        psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = wd;
        #1;
        check_val("prdata_setup", PRDATA, 32'h0);
        tick();
        penable = 1;
        if (sa) begin
            strobe   = 1;
            usb_data = sd;
        end
        #1;
        exp_err = m_err(a[4:2], w);
        exp_rd  = (w || exp_err) ? 32'h0 : m_rdata(a[4:2]);
        check_val($sformatf("pslverr@%02h", a[7:0]), 32'(PSLVERR), 32'(exp_err));
        check_val($sformatf("prdata@%02h", a[7:0]), PRDATA, exp_rd);
        rd       = PRDATA;
        last_err = PSLVERR;
        tick();
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
        logic [31:0] rd;
        apb(1'b1, a, d, 1'b0, 32'h0, rd);
    endtask

    task automatic apb_rd(input logic [11:0] a, output logic [31:0] rd);
        apb(1'b0, a, 32'h0, 1'b0, 32'h0, rd);
    endtask

    task automatic push_word(input logic [31:0] d);
        strobe = 1; usb_data = d;
        tick();
        strobe = 0;
        tick();
    endtask

    logic [31:0] wv[5] = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003,
                           32'hD3D3_0004, 32'hE4E4_0005};

    initial begin
        logic [31:0] rd;
        logic [31:0] nw;
        int          op;
        rst_n = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        usb_data = '0; strobe = 0; ext = '0; last_err = 0;
        model_reset();
        @(negedge clk);

        // Reset with the strobe toggling; release while it is high
        for (int i = 0; i < 6; i++) begin
            strobe = ~strobe; usb_data = $urandom;
            tick();
        end
        check_val("rst_prdata", PRDATA, 32'h0);
        check_val("rst_pslverr", 32'(PSLVERR), 32'h0);
        strobe = 1;
        rst_n  = 1;
        tick();
        strobe = 0;
        tick();
        apb_rd(12'h008, rd);
        check_val("rst_status", rd, 32'h0);

        // RX path with interrupt
        apb_wr(12'h014, 32'h1);
        push_word(32'hDEADBEEF);
        push_word(32'h12345678);
        tick();
        check_val("rx_irq_set", 32'(rx_irq_o), 32'h1);
        apb_rd(12'h008, rd);
        check_val("rx_status2", rd, 32'h11);
        apb_rd(12'h000, rd);
        check_val("rx_word0", rd, 32'hDEADBEEF);
        apb_rd(12'h000, rd);
        check_val("rx_word1", rd, 32'h12345678);
        apb_rd(12'h000, rd);
        check_val("rx_empty_err", 32'(last_err), 32'h1);
        check_val("rx_empty_data", rd, 32'h0);
        tick();
        check_val("rx_irq_clr", 32'(rx_irq_o), 32'h0);

        // Overrun
        for (int i = 0; i < 5; i++) push_word(wv[i]);
        apb_rd(12'h008, rd);
        check_val("ovr_status", rd, 32'h25);
        for (int i = 0; i < 4; i++) begin
            apb_rd(12'h000, rd);
            check_val($sformatf("ovr_word%0d", i), rd, wv[i]);
        end
        apb_rd(12'h000, rd);
        check_val("ovr_5th_absent", 32'(last_err), 32'h1);
        apb_wr(12'h014, 32'h3);
        apb_rd(12'h008, rd);
        check_val("ovr_cleared", rd, 32'h0);

        // Full FIFO: push coincident with pop
        for (int i = 0; i < 4; i++) push_word(wv[i] ^ 32'hFFFF_0000);
        nw = 32'h5A5A_A5A5;
        apb(1'b0, 12'h000, 32'h0, 1'b1, nw, rd);
        check_val("pp_head", rd, wv[0] ^ 32'hFFFF_0000);
        strobe = 0;
        tick();
        apb_rd(12'h008, rd);
        check_val("pp_status", rd, 32'h21);
        for (int i = 0; i < 4; i++) apb_rd(12'h000, rd);
        check_val("pp_tail", rd, nw);

        // TX handshake
        apb_wr(12'h004, 32'hCAFEF00D);
        check_val("tx_data", pulp_data_o, 32'hCAFEF00D);
        check_val("tx_pend_set", 32'(pulp_flags_o[0]), 32'h1);
        ext = 32'h1;
        tick();
        tick();
        check_val("tx_pend_hold", 32'(pulp_flags_o[0]), 32'h1);
        tick();
        check_val("tx_pend_ack", 32'(pulp_flags_o[0]), 32'h0);
        apb_rd(12'h00C, rd);
        check_val("ext_flags", rd, 32'h1);
        ext = 32'h0;
        repeat (4) tick();
        apb_wr(12'h004, 32'h1111_1111);
        ext = 32'h1;
        tick();
        apb_wr(12'h004, 32'h2222_2222);
        check_val("tx_write_wins", 32'(pulp_flags_o[0]), 32'h1);
        repeat (3) tick();
        check_val("tx_no_reack", 32'(pulp_flags_o[0]), 32'h1);

        // Decode errors and PULP_FLAGS
        apb_wr(12'h000, $urandom);
        check_val("wr_rx_err", 32'(last_err), 32'h1);
        apb_wr(12'h00C, $urandom);
        check_val("wr_ext_err", 32'(last_err), 32'h1);
        apb_wr(12'h018, $urandom);
        check_val("wr_oob_err", 32'(last_err), 32'h1);
        ext = 32'h0;
        repeat (3) tick();
        ext = 32'h1;
        repeat (4) tick();
        apb_wr(12'h010, 32'hFFFF_FFFF);
        check_val("pflags_out", pulp_flags_o, 32'hFFFF_FFFE);

        // Random traffic
        for (int it = 0; it < 500; it++) begin
            op = $urandom_range(0, 12);
            if (op <= 2) begin
                strobe = 0;
                if ($urandom_range(0, 1) == 1) tick();
                usb_data = $urandom;
                strobe = 1;
                repeat ($urandom_range(1, 3)) tick();
                strobe = 0;
                tick();
            end else if (op <= 4) begin
                apb(1'b0, 12'({$urandom_range(0, 7), 2'b00}), 32'h0,
                    1'($urandom_range(0, 1)), $urandom, rd);
            end else if (op <= 6) begin
                apb_wr(12'({$urandom_range(0, 7), 2'b00}), $urandom);
            end else if (op == 7) begin
                apb(1'b0, 12'h000, 32'h0, 1'($urandom_range(0, 1)), $urandom, rd);
                strobe = 0;
            end else if (op == 8) begin
                ext = $urandom;
                repeat ($urandom_range(1, 4)) tick();
            end else if (op == 9) begin
                ext[0] = ~ext[0];
                repeat ($urandom_range(1, 4)) tick();
            end else if (op == 10) begin
                apb_wr(12'h014, 32'($urandom_range(0, 3)));
            end else if (op == 11) begin
                apb_wr(12'h004, $urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                rst_n = 0;
                model_reset();
                #1;
                check_val("async_rst_data", pulp_data_o, 32'h0);
                check_val("async_rst_flags", pulp_flags_o, 32'h0);
                strobe = 1'($urandom_range(0, 1));
                tick();
                tick();
                rst_n = 1;
                tick();
            end else begin
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
